multicycle_datapath: RTL and testbench
======================================

Name: multicycle_datapath

Overview:
Parametrised multi-cycle successor to the single-cycle MIPS-style datapath. It accepts one instruction plus its control bundle through a valid/ready handshake and sequences it through DECODE/EXECUTE/MEMORY/WRITEBACK states. Data memory is external and reached through a req/ack handshake, so wait states are supported. Register file and ALU are internal, and the block sits between the control unit and the data-memory port.

Parameters:
DATA_W, 32, datapath/register/memory word width (>=16)
NUM_REGS, 32, register count; index width RA_W = clog2(NUM_REGS), fields taken from instruction bits [25:21]/[20:16]/[15:11], low RA_W bits
MEM_ADDR_W, 10, word-address width of external data memory

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
instr_valid  in  1  instruction + controls presented
instr_ready  out  1  block idle, will accept
instruction  in  32  MIPS R/I-format word
reg_dst  in  1  1: dest=[15:11], 0: dest=[20:16]
reg_write  in  1  write register file in WRITEBACK
alu_src  in  1  1: ALU B = sign-extended imm, 0: RD2
alu_control  in  4  ALU op
mem_read  in  1  load
mem_write  in  1  store
mem_to_reg  in  1  1: writeback MDR, 0: ALU result
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 write, 0 read; valid with mem_req
mem_addr  out  MEM_ADDR_W  ALU result [MEM_ADDR_W-1:0]
mem_wdata  out  DATA_W  latched RD2
mem_rdata  in  DATA_W  read data, sampled on ack
mem_ack  in  1  one-cycle completion strobe
done  out  1  one-cycle pulse in WRITEBACK
rd1, rd2  out  DATA_W  latched register operands A/B
rd  out  DATA_W  latched memory read data (MDR)
alu_result  out  DATA_W  latched ALU output
zero  out  1  alu_result == 0

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; instr_ready=1; mem_req, mem_we, done=0; rd1, rd2, rd, alu_result, mem_addr, mem_wdata=0; zero=1; all registers cleared. Reset mid-operation aborts: no regfile write, mem_req dropped next cycle.
- IDLE: instr_ready=1. On instr_valid, latch instruction and all controls, go to DECODE. Inputs are ignored in every other state.
- DECODE: rd1<=R[rs], rd2<=R[rt], imm<=sign-extend([15:0]) to DATA_W. Go to EXECUTE.
- EXECUTE: alu_result<=ALU(rd1, alu_src?imm:rd2). Go to MEMORY if mem_read|mem_write, else WRITEBACK.
- ALU ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR, others give 0. Arithmetic wraps mod 2^DATA_W; overflow is not flagged.
- MEMORY: mem_req=1 with mem_addr/mem_we/mem_wdata stable until the cycle mem_ack=1 (inclusive). Ack may arrive in the first MEMORY cycle; there is no timeout. If mem_write and mem_read are both set, the store wins (mem_we=1) and rd is unchanged. On ack of a read, rd<=mem_rdata. Go to WRITEBACK. mem_ack outside MEMORY is ignored.
- WRITEBACK: done=1. If reg_write and dest!=0, R[dest]<=mem_to_reg?rd:alu_result. Writes to R0 are dropped and R0 always reads 0. Go to IDLE.
- Latency from accept edge to done: ALU instruction 3 cycles. Memory instruction 4+N cycles, where N = cycles mem_req waits before ack. Next accept is earliest the cycle after done.
- The regfile is written only in WRITEBACK, so there are no read/write hazards within one instruction.

Decomposition:
- Package dp_pkg: ALU opcode constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR), state enum (IDLE, DECODE, EXECUTE, MEMORY, WRITEBACK), instruction field bit positions.
- Sub-module regfile_2r1w: parametrised by DATA_W/NUM_REGS, with two combinational reads, one synchronous write, R0 hardwired to zero, and sync active-low clear.

Test Plan:
- Reset then ADDI R1=R0+(-5) (alu_src=1, ctrl 0010, reg_write, reg_dst=0) -> done 3 cycles after accept; alu_result=0xFFFFFFFB; R1 reads 0xFFFFFFFB.
- SW R1 to addr R0+4, memory acks after 2 wait cycles -> mem_req high 3 cycles, mem_we=1, mem_addr=4, mem_wdata=0xFFFFFFFB; done 6 cycles after accept; no regfile change.
- LW R2 from addr 4 (mem_rdata=0x12345678, ack on first MEMORY cycle) -> rd=0x12345678, R2=0x12345678, done 4 cycles after accept.
- R-type SLT R3=R1,R2 (reg_dst=1, ctrl 0111) -> alu_result=1 (signed -5<0x12345678); SUB R4=R2,R2 -> alu_result=0, zero=1.
- Write to R0 (ADD R0=R2+R2, reg_write=1) -> R0 still reads 0; instr_valid held high during busy states -> only one accept, instr_ready low until IDLE.
- Assert rst_n=0 while in MEMORY with mem_req high -> next cycle state IDLE, mem_req=0, done never pulses, all registers read 0.

Source files
------------

// File: rtl/multicycle_datapath_pkg.sv
// Shared definitions for the multi-cycle datapath: ALU opcodes, sequencer
// states and instruction field positions.
package dp_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK
  } state_e;

  // Low bit of each register field; fields are taken low-bits-first.
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RDF_LSB = 11;
  localparam int unsigned IMM_W   = 16;

endpackage

// File: rtl/multicycle_datapath_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// R0 hardwired to zero, synchronous active-low clear.
module regfile_2r1w #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [$clog2(NUM_REGS)-1:0] raddr1_i,
  input  logic [$clog2(NUM_REGS)-1:0] raddr2_i,
  output logic [DATA_W-1:0]           rdata1_o,
  output logic [DATA_W-1:0]           rdata2_o,
  input  logic                        we_i,
  input  logic [$clog2(NUM_REGS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]           wdata_i
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
    end else if (we_i && waddr_i != '0 && 32'(waddr_i) < NUM_REGS) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Out-of-range indices (non power-of-two NUM_REGS) read as zero like R0.
  assign rdata1_o = (raddr1_i == '0 || 32'(raddr1_i) >= NUM_REGS) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0 || 32'(raddr2_i) >= NUM_REGS) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-style datapath: accepts one instruction per handshake and
// walks it through DECODE/EXECUTE/MEMORY/WRITEBACK with an external data memory.
module multicycle_datapath
  import dp_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instruction,
  input  logic                  reg_dst,
  input  logic                  reg_write,
  input  logic                  alu_src,
  input  logic [3:0]            alu_control,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_to_reg,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  done,
  output logic [DATA_W-1:0]     rd1,
  output logic [DATA_W-1:0]     rd2,
  output logic [DATA_W-1:0]     rd,
  output logic [DATA_W-1:0]     alu_result,
  output logic                  zero
);

  localparam int RA_W = $clog2(NUM_REGS);

  state_e            state_q;
  logic              ready_q;
  logic [RA_W-1:0]   rs_q, rt_q, dst_q;
  logic [IMM_W-1:0]  imm16_q;
  logic              reg_write_q, alu_src_q, mem_read_q, mem_write_q, mem_to_reg_q;
  logic [3:0]        alu_ctrl_q;
  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q, alu_q, mdr_q;
  logic              mem_req_q, mem_we_q, done_q;

  logic [DATA_W-1:0] rf_rdata1, rf_rdata2, wb_data_d;
  logic [DATA_W-1:0] imm_d, alu_b, alu_d;
  logic              rf_we;
  logic              instr_unused;

  assign instr_unused = ^instruction[31:26];

  assign rf_we     = (state_q == WRITEBACK) && reg_write_q;
  assign wb_data_d = mem_to_reg_q ? mdr_q : alu_q;

  regfile_2r1w #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .raddr1_i(rs_q),
    .raddr2_i(rt_q),
    .rdata1_o(rf_rdata1),
    .rdata2_o(rf_rdata2),
    .we_i    (rf_we),
    .waddr_i (dst_q),
    .wdata_i (wb_data_d)
  );

  assign imm_d = DATA_W'($signed(imm16_q));

  always_comb begin
    alu_b = alu_src_q ? imm_q : rd2_q;
    alu_d = '0;
    case (alu_ctrl_q)
      ALU_AND: alu_d = rd1_q & alu_b;
      ALU_OR:  alu_d = rd1_q | alu_b;
      ALU_ADD: alu_d = rd1_q + alu_b;
      ALU_SUB: alu_d = rd1_q - alu_b;
      ALU_SLT: alu_d = {{(DATA_W-1){1'b0}}, ($signed(rd1_q) < $signed(alu_b))};
      ALU_NOR: alu_d = ~(rd1_q | alu_b);
      default: alu_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      rs_q         <= '0;
      rt_q         <= '0;
      dst_q        <= '0;
      imm16_q      <= '0;
      reg_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      alu_q        <= '0;
      mdr_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            // Destination is resolved at accept so reg_dst need not be kept.
            rs_q         <= instruction[RS_LSB +: RA_W];
            rt_q         <= instruction[RT_LSB +: RA_W];
            dst_q        <= reg_dst ? instruction[RDF_LSB +: RA_W] : instruction[RT_LSB +: RA_W];
            imm16_q      <= instruction[IMM_W-1:0];
            reg_write_q  <= reg_write;
            alu_src_q    <= alu_src;
            alu_ctrl_q   <= alu_control;
            mem_read_q   <= mem_read;
            mem_write_q  <= mem_write;
            mem_to_reg_q <= mem_to_reg;
            ready_q      <= 1'b0;
            state_q      <= DECODE;
          end
        end
        DECODE: begin
          rd1_q   <= rf_rdata1;
          rd2_q   <= rf_rdata2;
          imm_q   <= imm_d;
          state_q <= EXECUTE;
        end
        EXECUTE: begin
          alu_q <= alu_d;
          if (mem_read_q || mem_write_q) begin
            mem_req_q <= 1'b1;
            mem_we_q  <= mem_write_q;
            state_q   <= MEMORY;
          end else begin
            done_q  <= 1'b1;
            state_q <= WRITEBACK;
          end
        end
        MEMORY: begin
          if (mem_ack) begin
            if (!mem_write_q) mdr_q <= mem_rdata;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= WRITEBACK;
          end
        end
        WRITEBACK: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = alu_q[MEM_ADDR_W-1:0];
  assign mem_wdata   = rd2_q;
  assign done        = done_q;
  assign rd1         = rd1_q;
  assign rd2         = rd2_q;
  assign rd          = mdr_q;
  assign alu_result  = alu_q;
  assign zero        = (alu_q == '0);

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: directed and randomized instructions checked
// against an architectural register/MDR model and the ALU rules.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instruction = '0;
  logic        reg_dst = 1'b0, reg_write = 1'b0, alu_src = 1'b0;
  logic [3:0]  alu_control = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        done;
  logic [31:0] rd1, rd2, rd, alu_result;
  logic        zero;

  int checks = 0;
  int failures = 0;
  logic [31:0] mregs [32];
  logic [31:0] exp_mdr;

  always #5 clk = ~clk;

  multicycle_datapath #(
    .DATA_W    (32),
    .NUM_REGS  (32),
    .MEM_ADDR_W(10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instruction(instruction),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .alu_src    (alu_src),
    .alu_control(alu_control),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .done       (done),
    .rd1        (rd1),
    .rd2        (rd2),
    .rd         (rd),
    .alu_result (alu_result),
    .zero       (zero)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {6'h08, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rdf);
    return {6'h00, rs, rt, rdf, 5'd0, 6'h20};
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    exp_mdr = '0;
  endtask

  // One instruction end to end; abort_at>0 asserts reset on that mem_req cycle.
  task automatic run_instr(input logic [31:0] ins, input logic rdst, input logic rw, input logic asrc,
                           input logic [3:0] op, input logic mr, input logic mw, input logic m2r,
                           input int delay, input logic [31:0] rdata, input bit hold, input int abort_at);
    logic [4:0]  rs, rt, dest;
    logic [31:0] a, b2, imm, res, wb;
    int          cyc, reqs, exp_lat;
    bit          fin, seen_done, is_mem;
    rs   = ins[25:21];
    rt   = ins[20:16];
    dest = rdst ? ins[15:11] : ins[20:16];
    a    = mregs[rs];
    b2   = mregs[rt];
    imm  = {{16{ins[15]}}, ins[15:0]};
    res  = ref_alu(op, a, asrc ? imm : b2);
    is_mem  = mr | mw;
    exp_lat = is_mem ? 4 + delay : 3;

    @(negedge clk);
    check_eq("ready_idle", 32'(instr_ready), 32'd1);
    instruction = ins; reg_dst = rdst; reg_write = rw; alu_src = asrc;
    alu_control = op; mem_read = mr; mem_write = mw; mem_to_reg = m2r;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) instr_valid = 1'b0;
    instruction = $urandom; alu_control = 4'($urandom); reg_write = 1'($urandom);
    reg_dst = 1'($urandom); alu_src = 1'($urandom); mem_to_reg = 1'($urandom);
    mem_read = 1'($urandom); mem_write = 1'($urandom);

    cyc = 1; reqs = 0; fin = 1'b0;
    while (!fin && cyc < 64) begin
      mem_ack = 1'b0;
      check_eq("ready_busy", 32'(instr_ready), 32'd0);
      if (mem_req) begin
        reqs++;
        check_eq("mem_we", 32'(mem_we), 32'(mw));
        check_eq("mem_addr", 32'(mem_addr), {22'd0, res[9:0]});
        check_eq("mem_wdata", mem_wdata, b2);
        if (abort_at != 0 && reqs == abort_at) begin
          rst_n = 1'b0;
          @(posedge clk); #1;
          check_eq("abort_req", 32'(mem_req), 32'd0);
          check_eq("abort_ready", 32'(instr_ready), 32'd1);
          instr_valid = 1'b0;
          rst_n = 1'b1;
          reset_model();
          seen_done = done;
          repeat (6) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
          end
          check_eq("abort_no_done", 32'(seen_done), 32'd0);
          return;
        end
        if (reqs - 1 == delay) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end else begin
          mem_rdata = $urandom;
        end
      end else begin
        // Stray acks outside MEMORY must have no effect.
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      if (done) begin
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!fin) begin
      check_eq("timeout", 32'd0, 32'd1);
      mem_ack = 1'b0; instr_valid = 1'b0;
      return;
    end

    check_eq("latency", 32'(cyc), 32'(exp_lat));
    check_eq("rd1", rd1, a);
    check_eq("rd2", rd2, b2);
    check_eq("alu_result", alu_result, res);
    check_eq("zero", 32'(zero), 32'(res == 32'd0));
    check_eq("req_cycles", 32'(reqs), is_mem ? 32'(delay + 1) : 32'd0);
    if (mr && !mw) exp_mdr = rdata;
    check_eq("mdr", rd, exp_mdr);
    wb = m2r ? exp_mdr : res;
    if (rw && dest != 5'd0) mregs[dest] = wb;

    @(posedge clk); #1;
    mem_ack = 1'b0;
    instr_valid = 1'b0;
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("ready_back", 32'(instr_ready), 32'd1);
  endtask

  initial begin
    logic [3:0]  ops [7];
    logic [31:0] ins;
    int          kind;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010};
    reset_model();

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(instr_ready), 32'd1);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rd1", rd1, 32'd0);
    check_eq("rst_rd2", rd2, 32'd0);
    check_eq("rst_rd", rd, 32'd0);
    check_eq("rst_alu", alu_result, 32'd0);
    check_eq("rst_zero", 32'(zero), 32'd1);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    // ADDI R1 = R0 + -5
    run_instr(mk_i(5'd0, 5'd1, 16'hFFFB), 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0, 0);
    // SW R1 -> [R0+4], two wait cycles
    run_instr(mk_i(5'd0, 5'd1, 16'd4), 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 2, 32'd0, 1'b0, 0);
    // LW R2 <- [R0+4], ack on first MEMORY cycle
    run_instr(mk_i(5'd0, 5'd2, 16'd4), 1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 0, 32'h12345678, 1'b0, 0);
    // SLT R3 = R1 < R2, SUB R4 = R2 - R2
    run_instr(mk_r(5'd1, 5'd2, 5'd3), 1'b1, 1'b1, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0, 0);
    run_instr(mk_r(5'd2, 5'd2, 5'd4), 1'b1, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0, 0);
    // ADD R0 = R2 + R2 with instr_valid held through the busy states
    run_instr(mk_r(5'd2, 5'd2, 5'd0), 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b1, 0);
    run_instr(mk_r(5'd0, 5'd3, 5'd5), 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0, 0);
    // Read and write both set: store wins, MDR keeps its value
    run_instr(mk_i(5'd0, 5'd6, 16'd8), 1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b1, 1, 32'hDEADBEEF, 1'b0, 0);
    run_instr(mk_r(5'd1, 5'd2, 5'd7), 1'b1, 1'b1, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      ins[15:11] = 5'($urandom_range(0, 7));
      kind = $urandom_range(0, 3);
      run_instr(ins, 1'($urandom), 1'($urandom), 1'($urandom), ops[$urandom_range(0, 6)],
                kind == 1 || kind == 3, kind == 2 || kind == 3, 1'($urandom),
                $urandom_range(0, 3), $urandom, 1'($urandom), 0);
    end

    // Reset while waiting on memory, then confirm the register file was cleared
    run_instr(mk_i(5'd0, 5'd7, 16'd8), 1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 10, 32'hCAFEF00D, 1'b0, 2);
    run_instr(mk_r(5'd1, 5'd2, 5'd8), 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0, 0);
    run_instr(mk_r(5'd3, 5'd4, 5'd9), 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
